// File: rtl/sw_event_arbiter.sv
// sw_event_arbiter
//
// Turns the four pending-event levels from sw_ctrlr_x4 into an ordered,
// timestamped event log. Pending events are granted one at a time in
// round-robin order. Each grant is acknowledged back to the controller with a
// one-cycle one-hot pulse and pushes a 32-bit record into a small FIFO. The
// FIFO drains through an AXI-Stream master port.
//
// Record layout: [1:0] switch index, [2] switch level at grant time,
//                [7:3] zero, [31:8] 24-bit free-running timestamp.
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   enable             allows new grants; the FIFO keeps draining when low
//   sw_event[3:0]      pending-event levels from sw_ctrlr_x4
//   sw_state[3:0]      filtered switch levels, captured into the record
//   sw_event_ack[3:0]  one-hot, one-cycle acknowledge pulse
//   m_axis_tdata/tvalid/tready  AXI-Stream master (first-word-fall-through)
//   fifo_level         current FIFO occupancy
//   overflow_cnt       dropped-event count (saturating)
//
// Optional feature (macro SW_EVENT_ARB_DROP_ON_FULL_EN):
//   defined   - a full FIFO does not stall the arbiter. Events are still
//               granted and acked, but no record is written and overflow_cnt
//               counts the drop, saturating at 255.
//   undefined - a full FIFO stalls grants, so events stay pending upstream.
//               overflow_cnt is tied to 0.

module sw_event_arbiter #(
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [3:0]                  sw_event,
  input  logic [3:0]                  sw_state,
  output logic [3:0]                  sw_event_ack,
  output logic [31:0]                 m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  overflow_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ACK_TIMEOUT);
  localparam logic [LVL_W-1:0] DEPTH_VAL   = LVL_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    ACK_WAIT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [1:0]         grant_idx_reg;
  logic [1:0]         rr_ptr_reg;
  logic [3:0]         ack_reg;
  logic [23:0]        ts_reg;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]   level_reg;

  logic               pick_found;
  logic [1:0]         pick_idx;
  logic               fifo_full;
  logic               can_grant;
  logic               grant;
  logic               push;
  logic               pop;
  logic [31:0]        record;

  // Fullness comes from the registered level only, so a pop in the same
  // cycle cannot make room for a push until the following cycle.
  assign fifo_full = (level_reg == DEPTH_VAL);

`ifdef SW_EVENT_ARB_DROP_ON_FULL_EN
  assign can_grant = 1'b1;
`else
  assign can_grant = !fifo_full;
`endif

  // Round-robin pick: first set bit scanning upward from rr_ptr, wrapping mod 4.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_reg;
    for (int i = 0; i < 4; i++) begin
      if (!pick_found && sw_event[rr_ptr_reg + 2'(i)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_ptr_reg + 2'(i);
      end
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    grant         = 1'b0;
    case (state_reg)
      IDLE: begin
        wait_cnt_next = '0;
        if (enable && pick_found && can_grant) begin
          grant      = 1'b1;
          state_next = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        // The first ACK_WAIT cycle is the ack cycle itself. The controller
        // cannot have cleared the bit yet, so the level is ignored there.
        if (((wait_cnt_reg != '0) && !sw_event[grant_idx_reg]) ||
            (wait_cnt_reg == TIMEOUT_VAL)) begin
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign push   = grant && !fifo_full;
  assign pop    = m_axis_tvalid && m_axis_tready;
  assign record = {ts_reg, 5'b0, sw_state[pick_idx], pick_idx};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      grant_idx_reg <= 2'd0;
      rr_ptr_reg    <= 2'd0;
      ack_reg       <= 4'd0;
      ts_reg        <= 24'd0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      ts_reg       <= ts_reg + 24'd1;
      ack_reg      <= grant ? (4'b0001 << pick_idx) : 4'b0000;
      if (grant) begin
        grant_idx_reg <= pick_idx;
        rr_ptr_reg    <= pick_idx + 2'd1;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage has no reset. Contents are only visible through the gated head
  // read below, so stale words never reach the port.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_reg] <= record;
  end

  assign m_axis_tvalid = (level_reg != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr_reg] : 32'd0;
  assign sw_event_ack  = ack_reg;
  assign fifo_level    = level_reg;

`ifdef SW_EVENT_ARB_DROP_ON_FULL_EN
  logic       overflow_hit;
  logic [7:0] ovf_reg;

  assign overflow_hit = grant && fifo_full;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ovf_reg <= 8'd0;
    end else if (overflow_hit && (ovf_reg != 8'hFF)) begin
      ovf_reg <= ovf_reg + 8'd1;
    end
  end

  assign overflow_cnt = ovf_reg;
`else
  assign overflow_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sw_event_arbiter.sv
// tb_sw_event_arbiter
//
// Randomized bench for sw_event_arbiter. A small behavioural sw_ctrlr_x4
// stand-in raises events and clears each one the cycle after its ack, or
// sometimes leaves it held so that the ack timeout is exercised. The
// reference model tracks arbitration by grant timestamps and keeps the FIFO
// as a queue of expected records.
//
// The bench prints one line for each record that leaves the stream port.

module tb_sw_event_arbiter;

  localparam int DEPTH = 8;
  localparam int TMO   = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef SW_EVENT_ARB_DROP_ON_FULL_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             enable = 1'b0;
  logic [3:0]       sw_event = 4'd0;
  logic [3:0]       sw_state = 4'd0;
  logic [3:0]       sw_event_ack;
  logic [31:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b0;
  logic [LVL_W-1:0] fifo_level;
  logic [7:0]       overflow_cnt;

  always #5 aclk = ~aclk;

  sw_event_arbiter #(
    .FIFO_DEPTH  (DEPTH),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .sw_event      (sw_event),
    .sw_state      (sw_state),
    .sw_event_ack  (sw_event_ack),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_level    (fifo_level),
    .overflow_cnt  (overflow_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] exp_q[$];
  int          m_cyc;
  int          m_rr;
  bit          m_busy;
  int          m_gcyc;
  int          m_gidx;
  logic [3:0]  m_ack;
  int          m_ovf;

  // controller stand-in state and stimulus knobs
  logic [3:0]  clr_mask;
  logic [3:0]  inject;
  int          p_raise;
  int          p_ready;
  int          p_sticky;
  int          p_en;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cyc    = 0;
    m_rr     = 0;
    m_busy   = 1'b0;
    m_gcyc   = 0;
    m_gidx   = 0;
    m_ack    = 4'd0;
    m_ovf    = 0;
    clr_mask = 4'd0;
  endtask

  // Called at a falling edge. It compares outputs, drives this cycle's
  // inputs, advances the model across the next rising edge, and returns at
  // the following falling edge.
  task automatic run_cycle();
    logic [3:0]  ev;
    logic [31:0] rec;
    bit          full;
    bit          pop;
    bit          push;
    int          g;

    check_eq("ack", 32'(sw_event_ack), 32'(m_ack));
    check_eq("tvalid", 32'(m_axis_tvalid), (exp_q.size() > 0) ? 32'd1 : 32'd0);
    if (exp_q.size() > 0) check_eq("tdata", m_axis_tdata, exp_q[0]);
    check_eq("level", 32'(fifo_level), 32'(exp_q.size()));
    check_eq("overflow", 32'(overflow_cnt), 32'(m_ovf));

    // controller stand-in: clear last cycle's acked bits, raise new ones
    ev = sw_event & ~clr_mask;
    for (int i = 0; i < 4; i++) begin
      if (!ev[i] && (int'($urandom_range(99)) < p_raise)) ev[i] = 1'b1;
    end
    ev            = ev | inject;
    sw_event      = ev;
    sw_state      = 4'($urandom);
    m_axis_tready = (int'($urandom_range(99)) < p_ready);
    enable        = (int'($urandom_range(99)) < p_en);
    clr_mask      = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (sw_event_ack[i] && (int'($urandom_range(99)) >= p_sticky)) clr_mask[i] = 1'b1;
    end

    // reference model for this cycle
    full  = (exp_q.size() == DEPTH);
    pop   = (exp_q.size() > 0) && m_axis_tready;
    push  = 1'b0;
    rec   = 32'd0;
    m_ack = 4'd0;
    if (m_busy) begin
      // Wait ends once the bit reads clear from two cycles after the grant,
      // or after ACK_TIMEOUT+1 waiting cycles.
      if (((m_cyc >= m_gcyc + 2) && !sw_event[m_gidx]) || (m_cyc == m_gcyc + TMO + 1))
        m_busy = 1'b0;
    end else if (enable && (sw_event != 4'd0) && (!full || DROP)) begin
      g = m_rr;
      while (!sw_event[g]) g = (g + 1) % 4;
      m_ack  = 4'd1 << g;
      m_rr   = (g + 1) % 4;
      m_busy = 1'b1;
      m_gcyc = m_cyc;
      m_gidx = g;
      if (!full) begin
        push = 1'b1;
        rec  = {24'(m_cyc), 5'b0, sw_state[g], 2'(g)};
      end else if (m_ovf < 255) begin
        m_ovf++;
      end
    end
    if (pop) begin
      $display("xfer sw=%0d state=%0d ts=%0d at cycle %0d",
               exp_q[0][1:0], exp_q[0][2], exp_q[0][31:8], m_cyc);
      void'(exp_q.pop_front());
    end
    if (push) exp_q.push_back(rec);

    @(posedge aclk);
    m_cyc++;
    @(negedge aclk);
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  task automatic set_knobs(input int raise, input int ready, input int sticky, input int en);
    p_raise  = raise;
    p_ready  = ready;
    p_sticky = sticky;
    p_en     = en;
  endtask

  initial begin
    inject = 4'd0;
    model_reset();
    set_knobs(0, 100, 0, 100);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;

    // single event at cycle 10
    run_n(10);
    inject = 4'b0100;
    run_cycle();
    inject = 4'b0000;
    run_n(20);

    // round-robin: all four at once, then bits 0 and 3
    inject = 4'b1111;
    run_cycle();
    inject = 4'b0000;
    run_n(20);
    inject = 4'b1001;
    run_cycle();
    inject = 4'b0000;
    run_n(15);

    // general traffic
    set_knobs(10, 70, 0, 90);
    run_n(400);

    // back-pressure: fill, then drain
    set_knobs(20, 0, 0, 100);
    run_n(60);
    set_knobs(0, 100, 0, 100);
    run_n(40);

    // held events exercise the ack timeout and rotation
    set_knobs(15, 80, 70, 100);
    run_n(400);
    set_knobs(0, 100, 0, 100);
    run_n(60);

    // long stall with heavy event load (drop counting when enabled)
    set_knobs(50, 0, 0, 100);
    run_n(1000);
    set_knobs(0, 100, 0, 100);
    run_n(50);

    // asynchronous reset in the middle of traffic
    set_knobs(30, 0, 0, 100);
    run_n(40);
    aresetn = 1'b0;
    #1;
    check_eq("rst_ack", 32'(sw_event_ack), 32'd0);
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tdata", m_axis_tdata, 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_overflow", 32'(overflow_cnt), 32'd0);
    repeat (2) @(negedge aclk);
    sw_event = 4'b1111;
    aresetn  = 1'b1;
    model_reset();
    set_knobs(0, 100, 0, 100);
    run_n(20);

    // mixed random traffic
    set_knobs(12, 60, 30, 85);
    run_n(300);
    set_knobs(0, 100, 0, 100);
    run_n(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
